// File: rtl/divider_share_sched.sv
// divider_share_sched
// One iterative 32/16 restoring divider shared round-robin between NUM_REQ
// requesters. Each requester has a valid/ready request channel. All results
// return on one valid/ready response channel tagged with the requester id.
// A zero divisor gives quot = all ones and rem = dividend, with rsp_dbz set.
module divider_share_sched #(
  parameter int NUM_REQ         = 4,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*16-1:0]      req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_quot,
  output logic [31:0]                rsp_rem,
  output logic                       rsp_dbz,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int RUN_CYCLES = 32 / STEPS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Control state
  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [4:0]        r_cnt;

  // Divider datapath: partial remainder, shifting dividend/quotient, divisor
  logic [16:0]       r_rem;
  logic [31:0]       r_quo;
  logic [15:0]       r_div;

  // Registered response
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [31:0]       r_rsp_quot;
  logic [31:0]       r_rsp_rem;
  logic              r_rsp_dbz;

  // Combinational helpers
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt_id;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [31:0]       w_a;
  logic [15:0]       w_b;
  logic [NUM_REQ-1:0] w_ready;
  logic [16:0]       w_rem_nxt;
  logic [31:0]       w_quo_nxt;

  // Requester index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] f_wrap(input int unsigned v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // One restoring step: shift {r,q} left by one, subtract divisor when it fits.
  // The shifted remainder is held one bit wider than r so the carry is never lost.
  function automatic logic [48:0] f_step(input logic [16:0] r,
                                         input logic [31:0] q,
                                         input logic [15:0] d);
    logic [17:0] t;
    logic [31:0] qs;
    t  = {r, q[31]};
    qs = {q[30:0], 1'b0};
    if (t >= {2'b00, d}) begin
      t     = t - {2'b00, d};
      qs[0] = 1'b1;
    end
    return {t[16:0], qs};
  endfunction

  // Round-robin search: first valid requester at or after r_ptr, with wrap.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_vld && req_valid[f_wrap(32'(r_ptr) + 32'(i))]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = f_wrap(32'(r_ptr) + 32'(i));
      end
    end
  end

  // Pointer moves one past the granted requester so it goes to the back of the line.
  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

  // Select the granted requester's operands.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == ID_W'(i)) begin
        w_a = req_a[i*32 +: 32];
        w_b = req_b[i*16 +: 16];
      end
    end
  end

  // Ready only in IDLE and only to the granted requester; forced low during reset.
  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_gnt_vld) begin
      w_ready[w_gnt_id] = 1'b1;
    end
  end

  // Unrolled restoring steps resolved in one clock.
  always_comb begin
    w_rem_nxt = r_rem;
    w_quo_nxt = r_quo;
    for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
      {w_rem_nxt, w_quo_nxt} = f_step(w_rem_nxt, w_quo_nxt, r_div);
    end
  end

  // Scheduler FSM: accept in IDLE, iterate in RUN, hold the response in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_quot  <= '0;
      r_rsp_rem   <= '0;
      r_rsp_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // --- accept boundary: operands captured from the granted requester
          if (w_gnt_vld) begin
            r_ptr    <= w_ptr_nxt;
            r_rsp_id <= w_gnt_id;
            if (w_b == 16'd0) begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_quot  <= 32'hFFFF_FFFF;
              r_rsp_rem   <= w_a;
              r_rsp_dbz   <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_rem   <= '0;
              r_quo   <= w_a;
              r_div   <= w_b;
              r_cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          // --- iteration boundary: STEPS_PER_CYCLE quotient bits per edge
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == LAST_CNT) begin
            r_cnt       <= '0;
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_quot  <= w_quo_nxt;
            r_rsp_rem   <= {16'd0, w_rem_nxt[15:0]};
            r_rsp_dbz   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DONE: begin
          // --- response boundary: release only on a completed handshake
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_quot  = r_rsp_quot;
  assign rsp_rem   = r_rsp_rem;
  assign rsp_dbz   = r_rsp_dbz;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_divider_share_sched.sv
// Bench for divider_share_sched: one instance with one quotient bit per clock,
// one with four bits per clock. Expected results come from plain integer
// division and a round-robin pick over the set of pending requesters.
module tb_divider_share_sched;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a;
  logic [63:0]  req_b;
  logic         rsp_valid, rsp_ready, rsp_dbz, busy;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_quot, rsp_rem;

  logic [3:0]   req_valid4, req_ready4;
  logic [127:0] req_a4;
  logic [63:0]  req_b4;
  logic         rsp_valid4, rsp_ready4, rsp_dbz4, busy4;
  logic [1:0]   rsp_id4;
  logic [31:0]  rsp_quot4, rsp_rem4;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_ptr  = 0;

  divider_share_sched #(.NUM_REQ(4), .STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  divider_share_sched #(.NUM_REQ(4), .STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_a(req_a4), .req_b(req_b4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4),
    .rsp_quot(rsp_quot4), .rsp_rem(rsp_rem4), .rsp_dbz(rsp_dbz4), .busy(busy4)
  );

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mdl_quot(input logic [31:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 32'hFFFF_FFFF : a / {16'd0, b};
  endfunction

  function automatic logic [31:0] mdl_rem(input logic [31:0] a, input logic [15:0] b);
    return (b == 16'd0) ? a : a % {16'd0, b};
  endfunction

  function automatic int mdl_lat(input logic [15:0] b, input int steps);
    return (b == 16'd0) ? 0 : 32 / steps;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_req(input int id, input logic [31:0] a, input logic [15:0] b);
    req_valid[id]     = 1'b1;
    req_a[id*32 +: 32] = a;
    req_b[id*16 +: 16] = b;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [15:0] b,
                       output logic [3:0] rdy);
    @(negedge clk);
    set_req(id, a, b);
    #1 rdy = req_ready;
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    mdl_ptr = (id + 1) % NREQ;
  endtask

  task automatic wait_rsp(output int lat, output bit to);
    lat = 0;
    to  = 1'b0;
    while (rsp_valid !== 1'b1) begin
      if (lat >= 100) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {16'd3, 16'd5, 16'd7, 16'd9};
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    n_checks++;
    if ({rsp_valid, busy, rsp_dbz, rsp_id} !== 5'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {rsp_valid, busy, rsp_dbz, rsp_id});
    end
    n_checks++;
    if ({rsp_quot, rsp_rem} !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {rsp_quot, rsp_rem});
    end
    @(negedge clk);
    req_valid = 4'h0;
    rst_n     = 1'b1;
    mdl_ptr   = 0;
  endtask

  task automatic test_basic();
    logic [3:0] rdy;
    int lat;
    bit to;
    issue(0, 32'd100, 16'd7, rdy);
    n_checks++;
    if (rdy !== 4'b0001) begin
      n_fail++; $display("FAIL basic_ready: got %b want 0001", rdy);
    end
    n_checks++;
    if (busy !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL basic_busy: got busy=%b ready=%b want 1/0000", busy, req_ready);
    end
    wait_rsp(lat, to);
    n_checks++;
    if (to || lat != mdl_lat(16'd7, 1)) begin
      n_fail++; $display("FAIL basic_latency: got %0d (timeout=%0b) want %0d", lat, to, mdl_lat(16'd7, 1));
    end
    n_checks++;
    if ({rsp_id, rsp_dbz, rsp_quot, rsp_rem} !== {2'd0, 1'b0, mdl_quot(100, 7), mdl_rem(100, 7)}) begin
      n_fail++; $display("FAIL basic_result: got id=%0d dbz=%b q=%0d r=%0d want 0/0/%0d/%0d",
                         rsp_id, rsp_dbz, rsp_quot, rsp_rem, mdl_quot(100, 7), mdl_rem(100, 7));
    end
    ack_rsp();
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: got busy=%b valid=%b want 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_edge_values();
    logic [31:0] ta [0:5];
    logic [15:0] tbv [0:5];
    logic [3:0] rdy;
    int lat;
    bit to;
    ta[0] = 32'hFFFF_FFFF; tbv[0] = 16'hFFFF;
    ta[1] = 32'd5;         tbv[1] = 16'd9;
    ta[2] = 32'hDEAD_BEEF; tbv[2] = 16'd1;
    ta[3] = 32'hFFFF_FFFF; tbv[3] = 16'd1;
    ta[4] = 32'd0;         tbv[4] = 16'd3;
    ta[5] = 32'h8000_0000; tbv[5] = 16'h8001;
    for (int k = 0; k < 6; k++) begin
      issue((k + 1) % NREQ, ta[k], tbv[k], rdy);
      wait_rsp(lat, to);
      n_checks++;
      if (to || lat != mdl_lat(tbv[k], 1)) begin
        n_fail++; $display("FAIL edge_latency[%0d]: got %0d (timeout=%0b) want %0d", k, lat, to, mdl_lat(tbv[k], 1));
      end
      n_checks++;
      if ({rsp_id, rsp_dbz} !== {2'((k + 1) % NREQ), 1'b0}) begin
        n_fail++; $display("FAIL edge_id[%0d]: got id=%0d dbz=%b want %0d/0", k, rsp_id, rsp_dbz, (k + 1) % NREQ);
      end
      n_checks++;
      if (rsp_quot !== mdl_quot(ta[k], tbv[k]) || rsp_rem !== mdl_rem(ta[k], tbv[k])) begin
        n_fail++; $display("FAIL edge_result[%0d]: got q=%h r=%h want q=%h r=%h", k, rsp_quot, rsp_rem,
                           mdl_quot(ta[k], tbv[k]), mdl_rem(ta[k], tbv[k]));
      end
      ack_rsp();
    end
  endtask

  task automatic test_dbz();
    logic [3:0] rdy;
    int lat;
    bit to;
    issue(2, 32'd1234, 16'd0, rdy);
    n_checks++;
    if (rdy !== 4'b0100) begin
      n_fail++; $display("FAIL dbz_ready: got %b want 0100", rdy);
    end
    wait_rsp(lat, to);
    n_checks++;
    if (to || lat != mdl_lat(16'd0, 1)) begin
      n_fail++; $display("FAIL dbz_latency: got %0d (timeout=%0b) want %0d", lat, to, mdl_lat(16'd0, 1));
    end
    n_checks++;
    if ({rsp_id, rsp_dbz, rsp_quot, rsp_rem} !== {2'd2, 1'b1, 32'hFFFF_FFFF, 32'd1234}) begin
      n_fail++; $display("FAIL dbz_result: got id=%0d dbz=%b q=%h r=%0d want 2/1/ffffffff/1234",
                         rsp_id, rsp_dbz, rsp_quot, rsp_rem);
    end
    ack_rsp();
  endtask

  task automatic test_round_robin();
    logic [31:0] ra [0:3];
    logic [15:0] rb [0:3];
    int order [0:4];
    int g;
    int lat;
    bit to;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = $urandom;
      rb[i] = 16'($urandom_range(1, 65535));
      set_req(i, ra[i], rb[i]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mdl_ptr = 0;
    #1;
    for (int j = 0; j < 5; j++) begin
      g = rr_pick(req_valid, mdl_ptr);
      n_checks++;
      if (req_ready !== (4'b0001 << g) || g != order[j]) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want onehot %0d", j, req_ready, order[j]);
      end
      mdl_ptr = (g + 1) % NREQ;
      @(posedge clk);
      #1;
      wait_rsp(lat, to);
      n_checks++;
      if (to || rsp_id !== 2'(g)) begin
        n_fail++; $display("FAIL rr_id[%0d]: got %0d (timeout=%0b) want %0d", j, rsp_id, to, g);
      end
      n_checks++;
      if (rsp_quot !== mdl_quot(ra[g], rb[g]) || rsp_rem !== mdl_rem(ra[g], rb[g])) begin
        n_fail++; $display("FAIL rr_result[%0d]: got q=%h r=%h want q=%h r=%h", j, rsp_quot, rsp_rem,
                           mdl_quot(ra[g], rb[g]), mdl_rem(ra[g], rb[g]));
      end
      ack_rsp();
    end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_hold();
    logic [3:0] rdy;
    logic [31:0] a;
    logic [15:0] b;
    int lat;
    bit to;
    a = $urandom;
    b = 16'($urandom_range(1, 65535));
    issue(1, a, b, rdy);
    wait_rsp(lat, to);
    req_valid = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (to || {rsp_valid, rsp_id, rsp_dbz, rsp_quot, rsp_rem} !== {1'b1, 2'd1, 1'b0, mdl_quot(a, b), mdl_rem(a, b)}) begin
        n_fail++; $display("FAIL hold_rsp[%0d]: got v=%b id=%0d q=%h r=%h want 1/1/%h/%h", c, rsp_valid,
                           rsp_id, rsp_quot, rsp_rem, mdl_quot(a, b), mdl_rem(a, b));
      end
      n_checks++;
      if (busy !== 1'b1 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL hold_busy[%0d]: got busy=%b ready=%b want 1/0000", c, busy, req_ready);
      end
    end
    ack_rsp();
    req_valid = 4'h0;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got busy=%b valid=%b want 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] rdy;
    int seen;
    int lat;
    bit to;
    issue(0, 32'd100, 16'd7, rdy);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, busy, rsp_dbz, rsp_id, req_ready} !== 9'd0 || {rsp_quot, rsp_rem} !== 64'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got v=%b busy=%b q=%h r=%h want all zero",
                         rsp_valid, busy, rsp_quot, rsp_rem);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mdl_ptr = 0;
    seen    = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 if (rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midrst_no_rsp: got %0d valid cycles want 0", seen);
    end
    issue(0, 32'd100, 16'd7, rdy);
    wait_rsp(lat, to);
    n_checks++;
    if (rdy !== 4'b0001 || to || lat != mdl_lat(16'd7, 1)
        || rsp_quot !== mdl_quot(100, 7) || rsp_rem !== mdl_rem(100, 7)) begin
      n_fail++; $display("FAIL midrst_reissue: got rdy=%b lat=%0d q=%0d r=%0d want 0001/32/14/2",
                         rdy, lat, rsp_quot, rsp_rem);
    end
    ack_rsp();
  endtask

  task automatic test_random();
    logic [31:0] pa [0:3];
    logic [15:0] pb [0:3];
    logic [3:0]  pend;
    int g;
    int lat;
    bit to;
    pend = 4'h0;
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || (pend == 4'h0 && i == NREQ - 1))) begin
          pa[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
          case ($urandom_range(0, 7))
            0:       pb[i] = 16'd0;
            1:       pb[i] = 16'd1;
            2:       pb[i] = 16'($urandom_range(1, 15));
            default: pb[i] = 16'($urandom_range(1, 65535));
          endcase
          pend[i] = 1'b1;
          set_req(i, pa[i], pb[i]);
        end
      end
      #1;
      g = rr_pick(pend, mdl_ptr);
      n_checks++;
      if (req_ready !== (4'b0001 << g)) begin
        n_fail++; $display("FAIL rand_grant[%0d]: got %b want onehot %0d (pending %b)", it, req_ready, g, pend);
      end
      mdl_ptr = (g + 1) % NREQ;
      @(posedge clk);
      #1;
      req_valid[g] = 1'b0;
      pend[g]      = 1'b0;
      wait_rsp(lat, to);
      n_checks++;
      if (to || lat != mdl_lat(pb[g], 1) || rsp_id !== 2'(g) || rsp_dbz !== (pb[g] == 16'd0)) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got lat=%0d id=%0d dbz=%b want %0d/%0d/%b", it, lat,
                           rsp_id, rsp_dbz, mdl_lat(pb[g], 1), g, (pb[g] == 16'd0));
      end
      n_checks++;
      if (rsp_quot !== mdl_quot(pa[g], pb[g]) || rsp_rem !== mdl_rem(pa[g], pb[g])) begin
        n_fail++; $display("FAIL rand_result[%0d]: a=%h b=%h got q=%h r=%h want q=%h r=%h", it, pa[g], pb[g],
                           rsp_quot, rsp_rem, mdl_quot(pa[g], pb[g]), mdl_rem(pa[g], pb[g]));
      end
      ack_rsp();
    end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_steps4();
    logic [31:0] ta [0:2];
    logic [15:0] tbv [0:2];
    logic [3:0] rdy;
    int lat;
    bit to;
    ta[0] = 32'd100;       tbv[0] = 16'd7;
    ta[1] = 32'hFFFF_FFFF; tbv[1] = 16'hFFFF;
    ta[2] = 32'd5;         tbv[2] = 16'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid4      = 4'b0001;
      req_a4[31:0]    = ta[k];
      req_b4[15:0]    = tbv[k];
      #1 rdy = req_ready4;
      @(posedge clk);
      #1 req_valid4 = 4'b0000;
      lat = 0;
      to  = 1'b0;
      while (rsp_valid4 !== 1'b1) begin
        if (lat >= 100) begin
          to = 1'b1;
          break;
        end
        @(posedge clk);
        #1 lat++;
      end
      n_checks++;
      if (rdy !== 4'b0001 || to || lat != mdl_lat(tbv[k], 4)) begin
        n_fail++; $display("FAIL s4_latency[%0d]: got rdy=%b lat=%0d (timeout=%0b) want 0001/%0d",
                           k, rdy, lat, to, mdl_lat(tbv[k], 4));
      end
      n_checks++;
      if ({rsp_id4, rsp_dbz4, rsp_quot4, rsp_rem4} !== {2'd0, 1'b0, mdl_quot(ta[k], tbv[k]), mdl_rem(ta[k], tbv[k])}) begin
        n_fail++; $display("FAIL s4_result[%0d]: got q=%h r=%h want q=%h r=%h", k, rsp_quot4, rsp_rem4,
                           mdl_quot(ta[k], tbv[k]), mdl_rem(ta[k], tbv[k]));
      end
      rsp_ready4 = 1'b1;
      @(posedge clk);
      #1 rsp_ready4 = 1'b0;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0; req_a  = '0; req_b  = '0; rsp_ready  = 1'b0;
    req_valid4 = '0; req_a4 = '0; req_b4 = '0; rsp_ready4 = 1'b0;
    test_reset();
    test_basic();
    test_edge_values();
    test_dbz();
    test_round_robin();
    test_hold();
    test_reset_mid_run();
    test_random();
    test_steps4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
